conv4_psum_accum: RTL and testbench

- Downstream stage of the Conv4 convolution core.
- Consumes the core's paired partial sums (sum1/sum2, 2*DW signed) and accumulates them over the input channels of one output pixel pair.
- Adds a per-run bias, then requantizes by rounding right-shift and saturation to DW signed.
- Emits the pixel pair on a valid/ready interface toward the feature-map write-back buffer.

---
 rtl/conv4_psum_accum_if.sv | 31 +++
 rtl/conv4_psum_accum.sv | 104 ++++++++++
 tb/tb_conv4_psum_accum.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/conv4_psum_accum_if.sv
// conv4_psum_accum_if: config, partial-sum input and pixel-pair output bundle of the Conv4 psum accumulator
interface conv4_psum_accum_if #(
  parameter int DW = 8,
  parameter int ACC_W = 2 * DW + 7
);
  logic i_cfg_start;
  logic [6:0] i_cfg_nch;
  logic [7:0] i_cfg_ngrp;
  logic [4:0] i_cfg_shift;
  logic signed [ACC_W-1:0] i_bias;
  logic i_valid;
  logic o_ready;
  logic signed [2*DW-1:0] i_sum1;
  logic signed [2*DW-1:0] i_sum2;
  logic o_valid;
  logic i_ready;
  logic signed [DW-1:0] o_pix1;
  logic signed [DW-1:0] o_pix2;
  logic o_busy;
  logic o_done;
  modport master (
    output i_cfg_start, i_cfg_nch, i_cfg_ngrp, i_cfg_shift, i_bias,
    output i_valid, i_sum1, i_sum2, i_ready,
    input o_ready, o_valid, o_pix1, o_pix2, o_busy, o_done
  );
  modport slave (
    input i_cfg_start, i_cfg_nch, i_cfg_ngrp, i_cfg_shift, i_bias,
    input i_valid, i_sum1, i_sum2, i_ready,
    output o_ready, o_valid, o_pix1, o_pix2, o_busy, o_done
  );
endinterface

// File: rtl/conv4_psum_accum.sv
// conv4_psum_accum: accumulates paired Conv4 partial sums over channels, adds bias, round-shifts and saturates to DW (ReLU clamp when PSUM_RELU_EN is defined)
module conv4_psum_accum #(
  parameter int DW = 8,
  parameter int CH_MAX = 64,
  parameter int ACC_W = 2 * DW + 7
) (
  input logic clk,
  input logic rst,
  conv4_psum_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, REQ, OUT} state_t;
  localparam logic signed [ACC_W:0] PMAX = (ACC_W+1)'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W:0] NMIN = -PMAX - 1;
  localparam logic [4:0] SH_MAX = ACC_W > 32 ? 5'd31 : 5'(ACC_W - 1);
  localparam logic [6:0] NCH_MAX = 7'(CH_MAX);
  state_t state, state_nx;
  logic [6:0] nch, ch_cnt, nch_in;
  logic [7:0] ngrp, grp_cnt;
  logic [4:0] shift;
  logic signed [ACC_W-1:0] bias, acc1, acc2;
  logic signed [DW-1:0] pix1, pix2;
  logic done, acc_ok, out_ok, last_ch, last_grp;
  function automatic logic signed [DW-1:0] requant(input logic signed [ACC_W-1:0] a, input logic [4:0] sh);
    logic [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    rnd = '0;
    if (sh != 5'd0) rnd[sh-5'd1] = 1'b1;
    r = ($signed({a[ACC_W-1], a}) + $signed(rnd)) >>> sh;
    r = r > PMAX ? PMAX : r < NMIN ? NMIN : r;
`ifdef PSUM_RELU_EN
    r = r[ACC_W] ? '0 : r;
`else
`endif
    return r[DW-1:0];
  endfunction
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [2*DW-1:0] s);
    return {{(ACC_W - 2 * DW){s[2*DW-1]}}, s};
  endfunction
  always_comb begin
    nch_in = bus.i_cfg_nch == 7'd0 ? 7'd1 : bus.i_cfg_nch > NCH_MAX ? NCH_MAX : bus.i_cfg_nch;
    acc_ok = state == ACC && bus.i_valid;
    out_ok = state == OUT && bus.i_ready;
    last_ch = ch_cnt == nch - 7'd1;
    last_grp = grp_cnt == ngrp - 8'd1;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.i_cfg_start ? ACC : IDLE) :
               state == ACC ? (acc_ok && last_ch ? REQ : ACC) :
               state == REQ ? OUT :
               out_ok ? (last_grp ? IDLE : ACC) : OUT;
  always_comb begin
    bus.o_ready = state == ACC;
    bus.o_valid = state == OUT;
    bus.o_busy = state != IDLE;
    bus.o_done = done;
    bus.o_pix1 = pix1;
    bus.o_pix2 = pix2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      nch <= '0;
      ngrp <= '0;
      shift <= '0;
      bias <= '0;
      acc1 <= '0;
      acc2 <= '0;
      ch_cnt <= '0;
      grp_cnt <= '0;
      pix1 <= '0;
      pix2 <= '0;
      done <= 1'b0;
    end else begin
      if (state == IDLE && bus.i_cfg_start) begin
        nch <= nch_in;
        ngrp <= bus.i_cfg_ngrp == 8'd0 ? 8'd1 : bus.i_cfg_ngrp;
        shift <= bus.i_cfg_shift > SH_MAX ? SH_MAX : bus.i_cfg_shift;
        bias <= bus.i_bias;
        acc1 <= bus.i_bias;
        acc2 <= bus.i_bias;
        ch_cnt <= '0;
        grp_cnt <= '0;
      end
      if (acc_ok) begin
        acc1 <= acc1 + sext(bus.i_sum1);
        acc2 <= acc2 + sext(bus.i_sum2);
        ch_cnt <= ch_cnt + 7'd1;
      end
      if (state == REQ) begin
        pix1 <= requant(acc1, shift);
        pix2 <= requant(acc2, shift);
      end
      // next pixel pair restarts from the bias latched at run start
      if (out_ok && !last_grp) begin
        grp_cnt <= grp_cnt + 8'd1;
        ch_cnt <= '0;
        acc1 <= bias;
        acc2 <= bias;
      end
      done <= out_ok && last_grp;
    end
  end
endmodule

// File: tb/tb_conv4_psum_accum.sv
// tb_conv4_psum_accum: directed vector table plus multi-cycle sequences for conv4_psum_accum
module tb_conv4_psum_accum;
  localparam int DW = 8;
  localparam int ACC_W = 23;
  typedef struct {
    int bias;
    int shift;
    int s1;
    int s2;
    int e1;
    int e2;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int n_out = 0;
  int n_done = 0;
  vec_t vecs[9];
  conv4_psum_accum_if #(.DW(DW), .ACC_W(ACC_W)) bus ();
  conv4_psum_accum #(.DW(DW), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.o_valid && bus.i_ready) n_out <= n_out + 1;
    if (bus.o_done) n_done <= n_done + 1;
  end
  function automatic int relu(int x);
`ifdef PSUM_RELU_EN
    return x < 0 ? 0 : x;
`else
    return x;
`endif
  endfunction
  task automatic chk(string n, int a, int e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic start(int nch, int ngrp, int shift, int bias);
    bus.i_cfg_nch = 7'(nch);
    bus.i_cfg_ngrp = 8'(ngrp);
    bus.i_cfg_shift = 5'(shift);
    bus.i_bias = 23'(bias);
    bus.i_cfg_start = 1'b1;
    @(negedge clk);
    bus.i_cfg_start = 1'b0;
  endtask
  task automatic beat(int s1, int s2);
    bus.i_valid = 1'b1;
    bus.i_sum1 = 16'(s1);
    bus.i_sum2 = 16'(s2);
    for (int k = 0; k < 20 && !bus.o_ready; k++) @(negedge clk);
    chk("beat_ready", int'(bus.o_ready), 1);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask
  task automatic wait_valid(string n);
    for (int k = 0; k < 20 && !bus.o_valid; k++) @(negedge clk);
    chk({n, "_valid"}, int'(bus.o_valid), 1);
  endtask
  task automatic get_out(string n, int e1, int e2, bit last);
    wait_valid(n);
    chk({n, "_pix1"}, bus.o_pix1, e1);
    chk({n, "_pix2"}, bus.o_pix2, e2);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk({n, "_done"}, int'(bus.o_done), int'(last));
    if (last) begin
      @(negedge clk);
      chk({n, "_done_drop"}, int'(bus.o_done), 0);
      chk({n, "_idle"}, int'(bus.o_busy), 0);
    end
  endtask
  initial begin
    int o0, d0;
    vecs[0] = '{-4, 2, 10, -2, 2, -1};
    vecs[1] = '{0, 0, 1000, -1000, 127, -128};
    vecs[2] = '{0, 1, 3, -3, 2, -1};
    vecs[3] = '{100, 4, -200, 500, -6, 38};
    vecs[4] = '{0, 31, 32767, -32768, 0, 0};
    vecs[5] = '{1048576, 8, 0, 0, 127, 127};
    vecs[6] = '{-1048576, 8, 0, 0, -128, -128};
    vecs[7] = '{0, 0, 127, -128, 127, -128};
    vecs[8] = '{0, 1, 255, -256, 127, -128};
    bus.i_cfg_start = 1'b0;
    bus.i_cfg_nch = '0;
    bus.i_cfg_ngrp = '0;
    bus.i_cfg_shift = '0;
    bus.i_bias = '0;
    bus.i_valid = 1'b0;
    bus.i_sum1 = '0;
    bus.i_sum2 = '0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", int'(bus.o_ready), 0);
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_done", int'(bus.o_done), 0);
    chk("rst_pix1", bus.o_pix1, 0);
    chk("rst_pix2", bus.o_pix2, 0);
    for (int i = 0; i < 9; i++) begin
      start(1, 1, vecs[i].shift, vecs[i].bias);
      beat(vecs[i].s1, vecs[i].s2);
      get_out($sformatf("vec%0d", i), relu(vecs[i].e1), relu(vecs[i].e2), 1'b1);
    end
    start(3, 1, 0, 0);
    chk("acc_busy", int'(bus.o_busy), 1);
    beat(1, 2);
    beat(3, 4);
    beat(5, 6);
    chk("acc_req_valid", int'(bus.o_valid), 0);
    chk("acc_req_ready", int'(bus.o_ready), 0);
    @(negedge clk);
    chk("acc_lat_valid", int'(bus.o_valid), 1);
    get_out("acc", 9, 12, 1'b1);
    o0 = n_out;
    d0 = n_done;
    start(2, 2, 0, 5);
    beat(1, 1);
    beat(2, 3);
    wait_valid("bp_hold");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", int'(bus.o_valid), 1);
      chk("bp_ready", int'(bus.o_ready), 0);
      chk("bp_pix1", bus.o_pix1, 8);
      chk("bp_pix2", bus.o_pix2, 9);
      @(negedge clk);
    end
    get_out("bp_g1", 8, 9, 1'b0);
    beat(10, -10);
    beat(0, 1);
    get_out("bp_g2", 15, relu(-4), 1'b1);
    chk("bp_outputs", n_out - o0, 2);
    chk("bp_dones", n_done - d0, 1);
    start(2, 1, 0, 0);
    bus.i_valid = 1'b1;
    bus.i_sum1 = 16'(4);
    bus.i_sum2 = 16'(4);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_sum1 = 16'(100);
    bus.i_sum2 = 16'(100);
    bus.i_cfg_start = 1'b1;
    bus.i_cfg_nch = 7'd1;
    bus.i_cfg_shift = 5'd3;
    @(negedge clk);
    bus.i_cfg_start = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_sum1 = 16'(6);
    bus.i_sum2 = -16'sd8;
    @(negedge clk);
    bus.i_valid = 1'b0;
    get_out("gap", 10, relu(-4), 1'b1);
    start(3, 1, 0, 0);
    beat(7, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", int'(bus.o_busy), 0);
    chk("mrst_ready", int'(bus.o_ready), 0);
    chk("mrst_valid", int'(bus.o_valid), 0);
    chk("mrst_done", int'(bus.o_done), 0);
    chk("mrst_pix1", bus.o_pix1, 0);
    chk("mrst_pix2", bus.o_pix2, 0);
    o0 = n_out;
    d0 = n_done;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    chk("mrst_no_out", n_out - o0, 0);
    chk("mrst_no_done", n_done - d0, 0);
    chk("mrst_still_idle", int'(bus.o_busy), 0);
    start(3, 1, 0, 0);
    beat(1, 2);
    beat(3, 4);
    beat(5, 6);
    get_out("post_rst", 9, 12, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
